// File: rtl/bus_ram_slave_pkg.sv
// Shared types and constants for the bus RAM slave.
// Holds the FSM state encoding and the wait-state limit.
package bus_ram_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE   = 2'd0,
    STATE_WAIT   = 2'd1,
    STATE_ACCESS = 2'd2,
    STATE_DONE   = 2'd3
  } state_t;

  localparam int MAX_WAIT   = 15;
  localparam int WAIT_CNT_W = $clog2(MAX_WAIT + 1);

endpackage

// File: rtl/bus_ram_slave_if.sv
// cs/rw/ready request bus between the bus master and the RAM slave.
interface bus_ram_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] addr;
  logic              cs;
  logic              rw;
  logic [BE_W-1:0]   be;
  logic [DATA_W-1:0] data_in;
  logic              ready;
  logic              err;
  logic [DATA_W-1:0] data_out;

  modport master (output addr, cs, rw, be, data_in,
                  input  ready, err, data_out);

  modport slave  (input  addr, cs, rw, be, data_in,
                  output ready, err, data_out);
endinterface

// File: rtl/bus_ram_slave_ram_sp_be.sv
// Single-port synchronous RAM with per-byte write enables and registered read.
// One narrow array per byte lane so each lane maps to its own write port.
module ram_sp_be #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16384,
  localparam int BE_W   = DATA_W / 8,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [BE_W-1:0]   we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  generate
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_reg;

      always_ff @(posedge clk) begin
        if (we[gi]) begin
          mem[addr] <= wdata[gi*8 +: 8];
        end
        if (en) begin
          rd_reg <= mem[addr];
        end
      end

      assign rdata[gi*8 +: 8] = rd_reg;
    end
  endgenerate

endmodule

// File: rtl/bus_ram_slave.sv
// Bus RAM slave: request FSM with programmable wait states, range check,
// byte-enabled writes and a one-cycle ready/err completion pulse.
module bus_ram_slave
  import bus_ram_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 16384,
  parameter int WAIT_CYCLES = 0
) (
  input  logic           clk,
  input  logic           reset_n,
  bus_ram_slave_if.slave bus
);

  localparam int BE_W   = DATA_W / 8;
  localparam int OFF    = $clog2(BE_W);
  localparam int WIDX_W = ADDR_W - OFF;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [WIDX_W:0]     DEPTH_EXT = (WIDX_W + 1)'(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    WAIT_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t                state_reg, state_next;
  logic [WAIT_CNT_W-1:0] cnt_reg, cnt_next;
  logic                  pend_reg, pend_next;
  logic                  pend_err_reg, pend_err_next;
  logic                  pend_rd_reg, pend_rd_next;
  logic                  ready_reg, err_reg, rd_valid_reg;

  logic [WIDX_W-1:0] word_idx;
  logic              in_range;
  logic              fire;
  logic [DATA_W-1:0] rdata;

  assign word_idx = bus.addr[ADDR_W-1:OFF];
  assign in_range = {1'b0, word_idx} < DEPTH_EXT;
  assign fire     = (state_reg == STATE_ACCESS) && bus.cs;

  generate
    if (OFF > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^bus.addr[OFF-1:0];
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    pend_next     = 1'b0;
    pend_err_next = 1'b0;
    pend_rd_next  = 1'b0;
    case (state_reg)
      STATE_IDLE: begin
        if (bus.cs) begin
          if (WAIT_CYCLES == 0) begin
            state_next = STATE_ACCESS;
          end else begin
            state_next = STATE_WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      STATE_WAIT: begin
        if (!bus.cs) begin
          state_next = STATE_IDLE;
        end else if (cnt_reg == '0) begin
          state_next = STATE_ACCESS;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      STATE_ACCESS: begin
        if (!bus.cs) begin
          state_next = STATE_IDLE;
        end else begin
          // The RAM output lands one edge later, so ready follows via pend.
          pend_next     = 1'b1;
          pend_err_next = !in_range;
          pend_rd_next  = bus.rw && in_range;
          state_next    = STATE_DONE;
        end
      end
      STATE_DONE: begin
        if (!bus.cs) begin
          state_next = STATE_IDLE;
        end
      end
      default: state_next = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= STATE_IDLE;
      cnt_reg      <= '0;
      pend_reg     <= 1'b0;
      pend_err_reg <= 1'b0;
      pend_rd_reg  <= 1'b0;
      ready_reg    <= 1'b0;
      err_reg      <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      pend_reg     <= pend_next;
      pend_err_reg <= pend_err_next;
      pend_rd_reg  <= pend_rd_next;
      ready_reg    <= pend_reg;
      err_reg      <= pend_err_reg;
      rd_valid_reg <= pend_rd_reg;
    end
  end

  ram_sp_be #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .en   (fire && bus.rw && in_range),
    .we   (bus.be & {BE_W{fire && !bus.rw && in_range}}),
    .addr (word_idx[IDX_W-1:0]),
    .wdata(bus.data_in),
    .rdata(rdata)
  );

  assign bus.ready    = ready_reg;
  assign bus.err      = err_reg;
  assign bus.data_out = rd_valid_reg ? rdata : '0;

endmodule

// File: tb/tb_bus_ram_slave.sv
// Scoreboard bench for bus_ram_slave: three instances (default, 3 wait states,
// 1024-word depth) sharing one clock, reset and request data lines.
module tb_bus_ram_slave;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  cs_d;
  logic [15:0] addr_d;
  logic        rw_d;
  logic [3:0]  be_d;
  logic [31:0] data_d;
  int          cur;
  logic        rdy, er;
  logic [31:0] dout;

  int          errors = 0;
  int          checks = 0;
  exp_t        sb [$];
  logic [31:0] mdl [int];

  always #5 clk = ~clk;

  bus_ram_slave_if #(.DATA_W(32), .ADDR_W(16)) bus0 ();
  bus_ram_slave_if #(.DATA_W(32), .ADDR_W(16)) bus1 ();
  bus_ram_slave_if #(.DATA_W(32), .ADDR_W(16)) bus2 ();

  assign bus0.addr = addr_d; assign bus0.rw = rw_d; assign bus0.be = be_d;
  assign bus0.data_in = data_d; assign bus0.cs = cs_d[0];
  assign bus1.addr = addr_d; assign bus1.rw = rw_d; assign bus1.be = be_d;
  assign bus1.data_in = data_d; assign bus1.cs = cs_d[1];
  assign bus2.addr = addr_d; assign bus2.rw = rw_d; assign bus2.be = be_d;
  assign bus2.data_in = data_d; assign bus2.cs = cs_d[2];

  bus_ram_slave dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  bus_ram_slave #(.WAIT_CYCLES(3)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
  bus_ram_slave #(.DEPTH(1024)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

  always_comb begin
    case (cur)
      1:       begin rdy = bus1.ready; er = bus1.err; dout = bus1.data_out; end
      2:       begin rdy = bus2.ready; er = bus2.err; dout = bus2.data_out; end
      default: begin rdy = bus0.ready; er = bus0.err; dout = bus0.data_out; end
    endcase
  end

  function automatic int wait_of(input int s);
    return (s == 1) ? 3 : 0;
  endfunction

  function automatic int depth_of(input int s);
    return (s == 2) ? 1024 : 16384;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input int s, input logic r, input logic [15:0] a,
                     input logic [31:0] d, input logic [3:0] b,
                     input int hold, input bit rst_at_ready);
    exp_t        e;
    exp_t        got;
    int          idx, key, k;
    logic [31:0] word;
    idx    = int'(a[15:2]);
    key    = s * 65536 + idx;
    e.err  = (idx >= depth_of(s));
    e.data = 32'h0;
    if (!e.err) begin
      word = mdl.exists(key) ? mdl[key] : 32'h0;
      if (r) begin
        e.data = word;
      end else begin
        for (int i = 0; i < 4; i++) if (b[i]) word[i*8 +: 8] = d[i*8 +: 8];
        mdl[key] = word;
      end
    end
    sb.push_back(e);
    cur = s; addr_d = a; rw_d = r; data_d = d; be_d = b;
    cs_d[s] = 1'b1;
    k = 0;
    do begin
      step();
      k++;
    end while (!rdy && k < 40);
    chk("latency", 32'(k - 1), 32'(2 + wait_of(s)));
    got = sb.pop_front();
    chk("err", {31'b0, er}, {31'b0, got.err});
    chk("data_out", dout, got.data);
    $display("txn dut%0d %s addr=%h be=%h wdata=%h -> rdata=%h err=%b lat=%0d",
             s, r ? "RD" : "WR", a, b, d, dout, er, k - 1);
    if (rst_at_ready) begin
      reset_n = 1'b0;
      #1;
      chk("rst_async_ready", {31'b0, rdy}, 32'h0);
      chk("rst_async_data", dout, 32'h0);
      cs_d[s] = 1'b0;
      step();
      reset_n = 1'b1;
    end else begin
      for (int h = 0; h < hold; h++) begin
        step();
        chk("single_pulse", {31'b0, rdy}, 32'h0);
      end
      chk("data_cleared", dout, 32'h0);
      cs_d[s] = 1'b0;
      step();
    end
  endtask

  task automatic abort_write(input int s, input logic [15:0] a, input logic [31:0] d);
    bit saw;
    cur = s; addr_d = a; rw_d = 1'b0; data_d = d; be_d = 4'hF;
    cs_d[s] = 1'b1;
    step();
    step();
    cs_d[s] = 1'b0;
    saw = 1'b0;
    repeat (8) begin
      step();
      if (rdy) saw = 1'b1;
    end
    chk("abort_no_ready", {31'b0, saw}, 32'h0);
    $display("txn dut%0d WR-ABORT addr=%h wdata=%h ready_seen=%b", s, a, d, saw);
  endtask

  task automatic rst_in_access(input logic [15:0] a, input logic [31:0] d);
    cur = 0; addr_d = a; rw_d = 1'b0; data_d = d; be_d = 4'hF;
    cs_d[0] = 1'b1;
    step();
    reset_n = 1'b0;
    #1;
    chk("rst_access_ready", {31'b0, rdy}, 32'h0);
    chk("rst_access_err", {31'b0, er}, 32'h0);
    chk("rst_access_data", dout, 32'h0);
    step();
    cs_d[0] = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    $display("txn dut0 WR-RESET addr=%h wdata=%h", a, d);
  endtask

  initial begin
    reset_n = 1'b0; cs_d = 3'b000; addr_d = '0; rw_d = 1'b0; be_d = '0; data_d = '0; cur = 0;
    repeat (2) step();
    for (int s = 0; s < 3; s++) begin
      cur = s;
      #1;
      chk("reset_ready", {31'b0, rdy}, 32'h0);
      chk("reset_err", {31'b0, er}, 32'h0);
      chk("reset_data", dout, 32'h0);
    end
    reset_n = 1'b1;
    step();

    txn(0, 1'b0, 16'h0010, 32'hA5A5_1234, 4'hF, 1, 1'b0);
    txn(0, 1'b1, 16'h0010, 32'h0,         4'h0, 1, 1'b0);
    txn(0, 1'b0, 16'h0020, 32'hFFFF_FFFF, 4'hF, 1, 1'b0);
    txn(0, 1'b0, 16'h0020, 32'h0000_0000, 4'h5, 1, 1'b0);
    txn(0, 1'b1, 16'h0020, 32'h0,         4'h0, 1, 1'b0);
    txn(0, 1'b0, 16'h0020, 32'h1234_5678, 4'h0, 1, 1'b0);
    txn(0, 1'b1, 16'h0023, 32'h0,         4'h0, 1, 1'b0);
    txn(0, 1'b1, 16'h0010, 32'h0,         4'h0, 5, 1'b0);
    txn(0, 1'b1, 16'h0020, 32'h0,         4'h0, 1, 1'b0);

    txn(1, 1'b0, 16'h0040, 32'hCAFE_F00D, 4'hF, 1, 1'b0);
    txn(1, 1'b1, 16'h0040, 32'h0,         4'h0, 1, 1'b0);
    abort_write(1, 16'h0040, 32'h0BAD_BEEF);
    txn(1, 1'b1, 16'h0040, 32'h0,         4'h0, 1, 1'b0);

    txn(2, 1'b0, 16'h0FFC, 32'h1357_2468, 4'hF, 1, 1'b0);
    txn(2, 1'b0, 16'h1000, 32'hFFFF_FFFF, 4'hF, 1, 1'b0);
    txn(2, 1'b1, 16'h1000, 32'h0,         4'h0, 1, 1'b0);
    txn(2, 1'b1, 16'hFFFC, 32'h0,         4'h0, 1, 1'b0);
    txn(2, 1'b1, 16'h0FFC, 32'h0,         4'h0, 1, 1'b0);

    txn(0, 1'b0, 16'h0030, 32'h1122_3344, 4'hF, 1, 1'b0);
    rst_in_access(16'h0030, 32'hDEAD_BEEF);
    txn(0, 1'b1, 16'h0030, 32'h0,         4'h0, 1, 1'b0);
    txn(0, 1'b1, 16'h0030, 32'h0,         4'h0, 1, 1'b1);
    txn(0, 1'b1, 16'h0010, 32'h0,         4'h0, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_ram_slave.md
Name: bus_ram_slave

Overview:
Parametrised successor of the single-port bus RAM slave used as the SystemC BFM target. It uses the same cs/rw/ready request protocol, generalised in four ways:
- parametrised data width, address width and depth
- per-byte write enables
- a programmable number of wait states before the response
- an error response for out-of-range addresses

It sits directly behind the SystemC bus BFM as the memory target of the simulation top level.

Parameters:
- DATA_W, 32, data bus width in bits; multiple of 8, minimum 8.
- ADDR_W, 16, byte-address width.
- DEPTH, 16384, number of DATA_W words; must be ≤ 2^(ADDR_W − log2(DATA_W/8)).
- WAIT_CYCLES, 0, extra cycles between request acceptance and access; range 0..15.
- BE_W, DATA_W/8, derived localparam; byte-enable width.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- addr  in  ADDR_W  byte address; word index = addr[ADDR_W-1:log2(BE_W)]; low bits ignored.
- cs  in  1  request; held high by the master until the transaction completes.
- rw  in  1  1 = read, 0 = write.
- be  in  BE_W  byte write enables; ignored on reads.
- data_in  in  DATA_W  write data.
- ready  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse, coincident with ready.
- data_out  out  DATA_W  read data, valid only while ready=1; zero otherwise.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, wait counter=0, ready=0, err=0, data_out=0. RAM contents are not reset.
- State machine: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - cs=1 with WAIT_CYCLES=0 → ACCESS.
  - cs=1 with WAIT_CYCLES>0 → WAIT, counter loaded with WAIT_CYCLES−1.
  - cs=0 → stay in IDLE.
- WAIT:
  - cs=0 → IDLE (abort).
  - counter=0 → ACCESS.
  - otherwise decrement the counter.
- ACCESS, at the next edge:
  - cs=0 → IDLE (abort): no write, no ready.
  - cs=1 → perform the access, register ready=1 and err, go to DONE.
- DONE: ready=0, err=0, data_out=0; stay until cs=0, then IDLE. cs must be low for at least one cycle between transactions.
- Latency: cs first sampled high at edge N → ready high for exactly the cycle following edge N+2+WAIT_CYCLES. With WAIT_CYCLES=0, ready is visible after edge N+2.
- Read in range: data_out ← ram[index] at the ACCESS edge; cleared to 0 at the next edge.
- Write in range: for each i with be[i]=1, ram[index] byte i ← data_in byte i. Lanes with be[i]=0 keep their old value. be=0 is a legal no-op write that still gets ready=1.
- Out of range (index ≥ DEPTH): no RAM access, data_out=0, ready=1 and err=1 together for one cycle.
- addr, rw, be and data_in are sampled at the ACCESS edge only and must be stable while cs=1.
- Reset asserted mid-transaction: immediate return to IDLE, outputs zeroed. A write not yet committed at the ACCESS edge is lost.
- Array index width is clog2(DEPTH); out-of-range detection compares the full word index against DEPTH.

Decomposition:
- Package bus_ram_pkg holds:
  - state_t enum {STATE_IDLE, STATE_WAIT, STATE_ACCESS, STATE_DONE}
  - helper constant MAX_WAIT=15
- One sub-module: ram_sp_be, a single-port synchronous RAM with per-byte write enable and registered read, parameterised by DATA_W and DEPTH. The top module holds the FSM, counter, range check and output registers.

Test Plan:
- Defaults; write addr 0x0010, data 0xA5A5_1234, be=0xF; drop cs; read 0x0010 → ready pulses 2 cycles after cs, data_out=0xA5A5_1234, err=0.
- Write 0xFFFF_FFFF to 0x0020; write 0x0000_0000 to 0x0020 with be=0x5; read → 0xFF00_FF00.
- WAIT_CYCLES=3; read → ready exactly 5 cycles after cs first sampled; drop cs in WAIT (cycle 2) on a write → no ready, memory unchanged on readback.
- DEPTH=1024, read/write addr 0x1000 (index 1024) → ready=1, err=1, data_out=0; index 1023 unaffected.
- Hold cs high after ready → single ready pulse only, no second access. cs low 1 cycle, then new read → normal completion.
- Assert reset_n low asynchronously in ACCESS of a write → ready/err/data_out=0 immediately, state IDLE, target word unchanged.
